// File: rtl/alu_instr_sequencer.sv
// Control-step sequencer for one register-register ALU instruction:
// fetch (T0-T2), decode (T3), execute/write-back (T4-T6), with start/done handshake.
module alu_instr_sequencer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   IR,
  output logic                out_PC,
  output logic                out_Z_LO,
  output logic                out_Z_HI,
  output logic                out_MDR,
  output logic                MAR_in,
  output logic                PC_in,
  output logic                MDR_in,
  output logic                IR_in,
  output logic                Y_in,
  output logic                Z_in,
  output logic                HI_in,
  output logic                LO_in,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [4:0]          alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  localparam int unsigned OP_W = 5;
  localparam int unsigned RF_W = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    C_BIN, C_HL, C_UN, C_ILL
  } op_class_t;

  state_t state, state_nxt;

  logic [OP_W-1:0] op_q;
  logic [RF_W-1:0] ra_q, rb_q, rc_q;

  logic [OP_W-1:0] ir_op;
  logic [RF_W-1:0] ir_ra, ir_rb, ir_rc;
  op_class_t       ir_class, q_class;
  logic            ir_legal;
  logic            ir_unused;

  function automatic op_class_t classify(input logic [OP_W-1:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: return C_BIN;
      5'd15, 5'd16:                                           return C_HL;
      5'd17, 5'd18:                                           return C_UN;
      default:                                                return C_ILL;
    endcase
  endfunction

  // One-hot register select; fields beyond NUM_REGS select nothing.
  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [RF_W-1:0] idx);
    logic [NUM_REGS-1:0] r;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      r[i] = (idx == RF_W'(i));
    end
    return r;
  endfunction

  function automatic logic reg_ok(input logic [RF_W-1:0] idx);
    return {1'b0, idx} < 5'(NUM_REGS);
  endfunction

  assign ir_op     = IR[31:27];
  assign ir_ra     = IR[26:23];
  assign ir_rb     = IR[22:19];
  assign ir_rc     = IR[18:15];
  assign ir_unused = ^IR;
  assign ir_class  = classify(ir_op);
  assign q_class   = classify(op_q);

  // Rc is only consulted by binary ops; every class uses Ra and Rb.
  assign ir_legal = (ir_class != C_ILL) && reg_ok(ir_ra) && reg_ok(ir_rb) &&
                    ((ir_class != C_BIN) || reg_ok(ir_rc));

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state <= S_IDLE;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_T3) begin
        op_q <= ir_op;
        ra_q <= ir_ra;
        rb_q <= ir_rb;
        rc_q <= ir_rc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    out_PC    = 1'b0;
    out_Z_LO  = 1'b0;
    out_Z_HI  = 1'b0;
    out_MDR   = 1'b0;
    MAR_in    = 1'b0;
    PC_in     = 1'b0;
    MDR_in    = 1'b0;
    IR_in     = 1'b0;
    Y_in      = 1'b0;
    Z_in      = 1'b0;
    HI_in     = 1'b0;
    LO_in     = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    reg_out   = '0;
    reg_in    = '0;
    alu_op    = '0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    illegal   = 1'b0;

    case (state)
      S_IDLE: if (start) state_nxt = S_T0;
      S_T0: begin
        out_PC    = 1'b1;
        MAR_in    = 1'b1;
        IncPC     = 1'b1;
        Z_in      = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        out_Z_LO = 1'b1;
        PC_in    = 1'b1;
        Read     = 1'b1;
        MDR_in   = 1'b1;
        if (mem_ready) state_nxt = S_T2;
      end
      S_T2: begin
        out_MDR   = 1'b1;
        IR_in     = 1'b1;
        state_nxt = S_T3;
      end
      // Decode straight from IR; the fields are captured on the way out.
      S_T3: begin
        case (ir_class)
          C_BIN: begin
            reg_out = reg_sel(ir_rb);
            Y_in    = 1'b1;
          end
          C_HL: begin
            reg_out = reg_sel(ir_ra);
            Y_in    = 1'b1;
          end
          default: ;
        endcase
        state_nxt = ir_legal ? S_T4 : S_ERR;
      end
      S_T4: begin
        alu_op    = op_q;
        Z_in      = 1'b1;
        reg_out   = (q_class == C_BIN) ? reg_sel(rc_q) : reg_sel(rb_q);
        state_nxt = S_T5;
      end
      S_T5: begin
        out_Z_LO = 1'b1;
        if (q_class == C_HL) begin
          LO_in     = 1'b1;
          state_nxt = S_T6;
        end else begin
          reg_in    = reg_sel(ra_q);
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_T6: begin
        out_Z_HI  = 1'b1;
        HI_in     = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        illegal   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer: AND, wait states, MUL, illegal ops,
// reset mid-instruction and back-to-back starts, plus an 8-register instance.
module tb_alu_instr_sequencer;

  logic        Clock = 1'b0;
  logic        Clear, start, mem_ready;
  logic [31:0] IR;

  logic out_PC, out_Z_LO, out_Z_HI, out_MDR, MAR_in, PC_in, MDR_in, IR_in;
  logic Y_in, Z_in, HI_in, LO_in, IncPC, Read, busy, done, illegal;
  logic [15:0] reg_out, reg_in;
  logic [4:0]  alu_op;

  logic out_PC8, out_Z_LO8, out_Z_HI8, out_MDR8, MAR_in8, PC_in8, MDR_in8, IR_in8;
  logic Y_in8, Z_in8, HI_in8, LO_in8, IncPC8, Read8, busy8, done8, illegal8;
  logic [7:0] reg_out8, reg_in8;
  logic [4:0] alu_op8;

  int vectors     = 0;
  int miscompares = 0;

  // Control-bit masks, packed in the order used by obs16.
  localparam logic [16:0] B_PC   = 17'h10000, B_ZLO = 17'h08000, B_ZHI  = 17'h04000,
                          B_MDR  = 17'h02000, B_MAR = 17'h01000, B_PCI  = 17'h00800,
                          B_MDRI = 17'h00400, B_IRI = 17'h00200, B_Y    = 17'h00100,
                          B_Z    = 17'h00080, B_HI  = 17'h00040, B_LO   = 17'h00020,
                          B_INC  = 17'h00010, B_RD  = 17'h00008, B_BUSY = 17'h00004,
                          B_DONE = 17'h00002, B_ILL = 17'h00001;
  localparam logic [16:0] E_T0 = B_PC | B_MAR | B_INC | B_Z | B_BUSY;
  localparam logic [16:0] E_T1 = B_ZLO | B_PCI | B_RD | B_MDRI | B_BUSY;
  localparam logic [16:0] E_T2 = B_MDR | B_IRI | B_BUSY;

  alu_instr_sequencer #(.DATA_W(32), .NUM_REGS(16)) dut (
    .Clock(Clock), .Clear(Clear), .start(start), .mem_ready(mem_ready), .IR(IR),
    .out_PC(out_PC), .out_Z_LO(out_Z_LO), .out_Z_HI(out_Z_HI), .out_MDR(out_MDR),
    .MAR_in(MAR_in), .PC_in(PC_in), .MDR_in(MDR_in), .IR_in(IR_in), .Y_in(Y_in),
    .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in), .IncPC(IncPC), .Read(Read),
    .reg_out(reg_out), .reg_in(reg_in), .alu_op(alu_op), .busy(busy), .done(done),
    .illegal(illegal)
  );

  alu_instr_sequencer #(.DATA_W(32), .NUM_REGS(8)) dut8 (
    .Clock(Clock), .Clear(Clear), .start(start), .mem_ready(mem_ready), .IR(IR),
    .out_PC(out_PC8), .out_Z_LO(out_Z_LO8), .out_Z_HI(out_Z_HI8), .out_MDR(out_MDR8),
    .MAR_in(MAR_in8), .PC_in(PC_in8), .MDR_in(MDR_in8), .IR_in(IR_in8), .Y_in(Y_in8),
    .Z_in(Z_in8), .HI_in(HI_in8), .LO_in(LO_in8), .IncPC(IncPC8), .Read(Read8),
    .reg_out(reg_out8), .reg_in(reg_in8), .alu_op(alu_op8), .busy(busy8), .done(done8),
    .illegal(illegal8)
  );

  always #5 Clock = ~Clock;

  function automatic logic [53:0] obs16();
    return {out_PC, out_Z_LO, out_Z_HI, out_MDR, MAR_in, PC_in, MDR_in, IR_in,
            Y_in, Z_in, HI_in, LO_in, IncPC, Read, busy, done, illegal,
            reg_out, reg_in, alu_op};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Compare the full 16-register instance output snapshot, then advance one cycle.
  task automatic step(input string tag, input logic [16:0] c, input logic [15:0] ro,
                      input logic [15:0] ri, input logic [4:0] op);
    logic [53:0] o, e;
    o = obs16();
    e = {c, ro, ri, op};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
    tick();
  endtask

  task automatic check8(input string tag, input logic [11:0] e);
    logic [11:0] o;
    o = {illegal8, busy8, HI_in8, LO_in8, reg_in8};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic fetch(input string tag);
    step({tag, "_t0"}, E_T0, 16'h0, 16'h0, 5'd0);
    step({tag, "_t1"}, E_T1, 16'h0, 16'h0, 5'd0);
    step({tag, "_t2"}, E_T2, 16'h0, 16'h0, 5'd0);
  endtask

  initial begin
    Clear = 1'b0; start = 1'b1; mem_ready = 1'b1; IR = 32'h0;
    tick();
    tick();
    start = 1'b0;
    step("reset_idle", 17'h0, 16'h0, 16'h0, 5'd0);
    Clear = 1'b1;
    step("idle_hold", 17'h0, 16'h0, 16'h0, 5'd0);

    // AND R1,R2,R3
    IR = 32'h2891_8000;
    start = 1'b1;
    step("and_idle", 17'h0, 16'h0, 16'h0, 5'd0);
    start = 1'b0;
    fetch("and");
    step("and_t3", B_Y | B_BUSY, 16'h0004, 16'h0, 5'd0);
    step("and_t4", B_Z | B_BUSY, 16'h0008, 16'h0, 5'd5);
    step("and_t5", B_ZLO | B_BUSY | B_DONE, 16'h0, 16'h0002, 5'd0);
    step("and_end", 17'h0, 16'h0, 16'h0, 5'd0);

    // Same AND with three wait states in T1
    start = 1'b1;
    step("ws_idle", 17'h0, 16'h0, 16'h0, 5'd0);
    start = 1'b0;
    step("ws_t0", E_T0, 16'h0, 16'h0, 5'd0);
    mem_ready = 1'b0;
    step("ws_t1a", E_T1, 16'h0, 16'h0, 5'd0);
    step("ws_t1b", E_T1, 16'h0, 16'h0, 5'd0);
    step("ws_t1c", E_T1, 16'h0, 16'h0, 5'd0);
    mem_ready = 1'b1;
    step("ws_t1d", E_T1, 16'h0, 16'h0, 5'd0);
    step("ws_t2", E_T2, 16'h0, 16'h0, 5'd0);
    step("ws_t3", B_Y | B_BUSY, 16'h0004, 16'h0, 5'd0);
    step("ws_t4", B_Z | B_BUSY, 16'h0008, 16'h0, 5'd5);
    step("ws_t5", B_ZLO | B_BUSY | B_DONE, 16'h0, 16'h0002, 5'd0);
    step("ws_end", 17'h0, 16'h0, 16'h0, 5'd0);

    // MUL R5,R3
    IR = 32'h7A98_0000;
    start = 1'b1;
    step("mul_idle", 17'h0, 16'h0, 16'h0, 5'd0);
    start = 1'b0;
    fetch("mul");
    step("mul_t3", B_Y | B_BUSY, 16'h0020, 16'h0, 5'd0);
    step("mul_t4", B_Z | B_BUSY, 16'h0008, 16'h0, 5'd15);
    step("mul_t5", B_ZLO | B_LO | B_BUSY, 16'h0, 16'h0, 5'd0);
    step("mul_t6", B_ZHI | B_HI | B_BUSY | B_DONE, 16'h0, 16'h0, 5'd0);
    step("mul_end", 17'h0, 16'h0, 16'h0, 5'd0);

    // NOT R4,R6 (unary): silent T3, Rb driven in T4
    IR = 32'h9230_0000;
    start = 1'b1;
    step("not_idle", 17'h0, 16'h0, 16'h0, 5'd0);
    start = 1'b0;
    fetch("not");
    step("not_t3", B_BUSY, 16'h0, 16'h0, 5'd0);
    step("not_t4", B_Z | B_BUSY, 16'h0040, 16'h0, 5'd18);
    step("not_t5", B_ZLO | B_BUSY | B_DONE, 16'h0, 16'h0010, 5'd0);
    step("not_end", 17'h0, 16'h0, 16'h0, 5'd0);

    // Illegal opcode 31
    IR = 32'hF800_0000;
    start = 1'b1;
    step("ill_idle", 17'h0, 16'h0, 16'h0, 5'd0);
    start = 1'b0;
    fetch("ill");
    step("ill_t3", B_BUSY, 16'h0, 16'h0, 5'd0);
    step("ill_err", B_ILL | B_BUSY, 16'h0, 16'h0, 5'd0);
    step("ill_end", 17'h0, 16'h0, 16'h0, 5'd0);

    // AND R1,R2,R9: legal with 16 registers, illegal with 8
    IR = 32'h2894_8000;
    start = 1'b1;
    step("r9_idle", 17'h0, 16'h0, 16'h0, 5'd0);
    start = 1'b0;
    fetch("r9");
    step("r9_t3", B_Y | B_BUSY, 16'h0004, 16'h0, 5'd0);
    check8("r8_err", 12'h800 | 12'h400);
    step("r9_t4", B_Z | B_BUSY, 16'h0200, 16'h0, 5'd5);
    check8("r8_back_idle", 12'h000);
    step("r9_t5", B_ZLO | B_BUSY | B_DONE, 16'h0, 16'h0002, 5'd0);
    check8("r8_still_idle", 12'h000);
    step("r9_end", 17'h0, 16'h0, 16'h0, 5'd0);

    // Clear during T4 of AND, then a clean restart
    IR = 32'h2891_8000;
    start = 1'b1;
    step("rst_idle", 17'h0, 16'h0, 16'h0, 5'd0);
    start = 1'b0;
    fetch("rst");
    step("rst_t3", B_Y | B_BUSY, 16'h0004, 16'h0, 5'd0);
    Clear = 1'b0;
    start = 1'b1;
    step("rst_t4", B_Z | B_BUSY, 16'h0008, 16'h0, 5'd5);
    step("rst_cleared", 17'h0, 16'h0, 16'h0, 5'd0);
    Clear = 1'b1;
    step("rst_restart_idle", 17'h0, 16'h0, 16'h0, 5'd0);
    start = 1'b0;
    fetch("rst2");
    step("rst2_t3", B_Y | B_BUSY, 16'h0004, 16'h0, 5'd0);
    step("rst2_t4", B_Z | B_BUSY, 16'h0008, 16'h0, 5'd5);
    step("rst2_t5", B_ZLO | B_BUSY | B_DONE, 16'h0, 16'h0002, 5'd0);

    // start held high: one idle cycle between back-to-back instructions
    start = 1'b1;
    step("b2b_idle", 17'h0, 16'h0, 16'h0, 5'd0);
    fetch("b2b_a");
    step("b2b_a_t3", B_Y | B_BUSY, 16'h0004, 16'h0, 5'd0);
    step("b2b_a_t4", B_Z | B_BUSY, 16'h0008, 16'h0, 5'd5);
    step("b2b_a_t5", B_ZLO | B_BUSY | B_DONE, 16'h0, 16'h0002, 5'd0);
    step("b2b_gap", 17'h0, 16'h0, 16'h0, 5'd0);
    start = 1'b0;
    step("b2b_b_t0", E_T0, 16'h0, 16'h0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
